// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: FSM states, ALU operations
// and the opcode/funct values of the supported instruction subset.
package mips_pkg;

  typedef enum logic [2:0] {START, FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} aluOpT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mips_regfile.sv
// Architectural register file: two combinational read ports, one write port
// committed on the clock edge; register 0 is hardwired to zero.
module mips_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   raddrA,
  output logic [XLEN-1:0] rdataA,
  input  logic [AW-1:0]   raddrB,
  output logic [XLEN-1:0] rdataB,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdataA = (raddrA == '0) ? '0 : regs[raddrA];
  assign rdataB = (raddrB == '0) ? '0 : regs[raddrB];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core (add/sub/and/or/slt, addi, lw, sw, beq, j) with
// word-addressed instruction fetch and a req/ack handshake on both memories.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          PC_W     = 16,
  parameter int          NREGS    = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted
);

  localparam int AW = $clog2(NREGS);

  stateT           state, stateNext;
  aluOpT           aluOp;
  logic [31:0]     ir;
  logic [5:0]      opcode, funct;
  logic            isR, isAddi, isLw, isSw, isBeq, isJ, functOk, legal;
  logic [AW-1:0]   rsIdx, rtIdx, rdIdx, wIdx;
  logic [XLEN-1:0] rsVal, rtVal, immExt, aluB, aluRes, aluOut, storeData, mdr, wData;
  logic [PC_W-1:0] pcReg, pcPlus1, brTarget, jTarget, pcNext;
  logic            rfWe, retireNext;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign isR    = (opcode == OP_RTYPE);
  assign isAddi = (opcode == OP_ADDI);
  assign isLw   = (opcode == OP_LW);
  assign isSw   = (opcode == OP_SW);
  assign isBeq  = (opcode == OP_BEQ);
  assign isJ    = (opcode == OP_J);
  assign rsIdx  = ir[21 +: AW];
  assign rtIdx  = ir[16 +: AW];
  assign rdIdx  = ir[11 +: AW];

  always_comb begin
    aluOp   = ALU_ADD;
    functOk = 1'b0;
    if (isR) begin
      case (funct)
        FN_ADD: functOk = 1'b1;
        FN_SUB: begin aluOp = ALU_SUB; functOk = 1'b1; end
        FN_AND: begin aluOp = ALU_AND; functOk = 1'b1; end
        FN_OR:  begin aluOp = ALU_OR;  functOk = 1'b1; end
        FN_SLT: begin aluOp = ALU_SLT; functOk = 1'b1; end
        default: ;
      endcase
    end
  end

  assign legal = functOk || isAddi || isLw || isSw || isBeq || isJ;

  // ALU: B operand is rt for R-type, the sign-extended immediate otherwise
  assign immExt = XLEN'($signed(ir[15:0]));
  assign aluB   = isR ? rtVal : immExt;

  always_comb begin
    aluRes = '0;
    case (aluOp)
      ALU_ADD: aluRes = rsVal + aluB;
      ALU_SUB: aluRes = rsVal - aluB;
      ALU_AND: aluRes = rsVal & aluB;
      ALU_OR:  aluRes = rsVal | aluB;
      ALU_SLT: aluRes = {{(XLEN-1){1'b0}}, ($signed(rsVal) < $signed(aluB))};
      default: aluRes = '0;
    endcase
  end

  assign pcPlus1  = pcReg + PC_W'(1);
  assign brTarget = pcPlus1 + PC_W'($signed(ir[15:0]));

  if (PC_W > 26) begin : gJumpHi
    assign jTarget = {pcPlus1[PC_W-1:26], ir[25:0]};
  end else begin : gJumpLo
    assign jTarget = ir[PC_W-1:0];
  end

  assign pcNext = isJ ? jTarget : ((isBeq && (rsVal == rtVal)) ? brTarget : pcPlus1);

  always_comb begin
    stateNext = state;
    case (state)
      START:  stateNext = FETCH;
      FETCH:  if (imem_ack) stateNext = DECODE;
      DECODE: stateNext = legal ? EXEC : HALT;
      EXEC: begin
        if (isLw || isSw)       stateNext = MEM;
        else if (isBeq || isJ)  stateNext = FETCH;
        else                    stateNext = WB;
      end
      MEM:    if (dmem_ack) stateNext = isLw ? WB : FETCH;
      WB:     stateNext = FETCH;
      HALT:   stateNext = HALT;
      default: stateNext = START;
    endcase
  end

  assign retireNext = (state == WB) ||
                      ((state == MEM) && dmem_ack && isSw) ||
                      ((state == EXEC) && (isBeq || isJ));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= START;
      pcReg  <= PC_W'(RESET_PC);
      ir     <= '0;
      retire <= 1'b0;
    end else begin
      state  <= stateNext;
      retire <= retireNext;
      if ((state == FETCH) && imem_ack) ir <= imem_rdata;
      if (state == EXEC) pcReg <= pcNext;
    end
  end

  // Datapath holding registers carry no reset; they are always written before use
  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      aluOut    <= aluRes;
      storeData <= rtVal;
    end
    if ((state == MEM) && dmem_ack) mdr <= dmem_rdata;
  end

  assign rfWe  = (state == WB);
  assign wIdx  = isR ? rdIdx : rtIdx;
  assign wData = isLw ? mdr : aluOut;

  mips_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) uRegfile (
    .clk    (clk),
    .reset  (reset),
    .raddrA (rsIdx),
    .rdataA (rsVal),
    .raddrB (rtIdx),
    .rdataB (rtVal),
    .we     (rfWe),
    .waddr  (wIdx),
    .wdata  (wData)
  );

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pcReg;
  assign pc         = pcReg;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && isSw;
  assign dmem_addr  = aluOut;
  assign dmem_wdata = storeData;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: an instruction-level reference model fills
// retire/store scoreboards, memory responders add configurable wait states.
module tb_mips_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel, rstA, rstB;
  logic busIAck, busDAck;
  logic [31:0] busIData;
  logic [63:0] busDRdata;

  logic aIReq, aDReq, aDWe, aRet, aHalt;
  logic [15:0] aIAddr, aPc;
  logic [31:0] aDAddr, aDWdata;
  logic bIReq, bDReq, bDWe, bRet, bHalt;
  logic [15:0] bIAddr, bPc;
  logic [63:0] bDAddr, bDWdata;

  logic busIReq, busDReq, busDWe, busRet, busHalt;
  logic [15:0] busIAddr, busPc;
  logic [63:0] busDAddr, busDWdata;

  assign rstA = rst | sel;
  assign rstB = rst | ~sel;

  mips_multicycle_core dutA (
    .clk(clk), .reset(rstA), .imem_req(aIReq), .imem_addr(aIAddr), .imem_rdata(busIData),
    .imem_ack(busIAck), .dmem_req(aDReq), .dmem_we(aDWe), .dmem_addr(aDAddr),
    .dmem_wdata(aDWdata), .dmem_rdata(busDRdata[31:0]), .dmem_ack(busDAck), .pc(aPc),
    .retire(aRet), .halted(aHalt)
  );

  mips_multicycle_core #(.XLEN(64), .NREGS(8)) dutB (
    .clk(clk), .reset(rstB), .imem_req(bIReq), .imem_addr(bIAddr), .imem_rdata(busIData),
    .imem_ack(busIAck), .dmem_req(bDReq), .dmem_we(bDWe), .dmem_addr(bDAddr),
    .dmem_wdata(bDWdata), .dmem_rdata(busDRdata), .dmem_ack(busDAck), .pc(bPc),
    .retire(bRet), .halted(bHalt)
  );

  always_comb begin
    if (sel) begin
      busIReq = bIReq; busIAddr = bIAddr; busDReq = bDReq; busDWe = bDWe;
      busDAddr = bDAddr; busDWdata = bDWdata; busPc = bPc; busRet = bRet; busHalt = bHalt;
    end else begin
      busIReq = aIReq; busIAddr = aIAddr; busDReq = aDReq; busDWe = aDWe;
      busDAddr = {32'b0, aDAddr}; busDWdata = {32'b0, aDWdata}; busPc = aPc;
      busRet = aRet; busHalt = aHalt;
    end
  end

  int nChk = 0, nPass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  typedef struct { int lat; logic [15:0] pc; } latT;
  typedef struct { logic [63:0] addr; logic [63:0] data; } stT;
  latT expLat[$];
  stT  expSt[$];

  logic [31:0] imem [1024];
  logic [63:0] dmem [256];
  logic [63:0] mReg [32];
  logic [63:0] mMem [256];
  int iw, dw, xl, nr, cyc, lastRet, iCnt, dCnt;
  bit spur, monOn, expHalt, hValid, hWe;
  logic [63:0] hAddr, hData;

  function automatic logic [31:0] rT(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] iT(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] jT(int t);
    return {6'h02, 26'(t)};
  endfunction

  // Instruction-level reference: architectural effects and per-instruction latency
  task automatic runIss(input int maxSteps);
    logic [15:0] mpc, npc;
    logic [31:0] ins;
    logic [63:0] mask, a, b, imm, res, addr;
    int rs, rt, rd, wi, lat;
    bit wr;
    latT e;
    stT s;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < 32; i++) mReg[i] = '0;
    for (int i = 0; i < 256; i++) mMem[i] = '0;
    mpc = 16'd0;
    expHalt = 1'b0;
    for (int st = 0; st < maxSteps; st++) begin
      ins = imem[mpc[9:0]];
      rs = int'(ins[25:21]) % nr; rt = int'(ins[20:16]) % nr; rd = int'(ins[15:11]) % nr;
      a = mReg[rs]; b = mReg[rt];
      imm = {{48{ins[15]}}, ins[15:0]} & mask;
      npc = mpc + 16'd1; wr = 1'b0; wi = 0; res = '0; lat = 0;
      case (ins[31:26])
        6'h00: begin
          wr = 1'b1; wi = rd; lat = 4 + iw;
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = (xl == 64) ? {63'b0, $signed(a) < $signed(b)}
                                    : {63'b0, $signed(a[31:0]) < $signed(b[31:0])};
            default: begin expHalt = 1'b1; return; end
          endcase
        end
        6'h08: begin wr = 1'b1; wi = rt; res = a + imm; lat = 4 + iw; end
        6'h23: begin
          addr = (a + imm) & mask;
          wr = 1'b1; wi = rt; res = mMem[addr[7:0]]; lat = 5 + iw + dw;
        end
        6'h2B: begin
          addr = (a + imm) & mask;
          s.addr = addr; s.data = b; expSt.push_back(s);
          mMem[addr[7:0]] = b; lat = 4 + iw + dw;
        end
        6'h04: begin lat = 3 + iw; if (a == b) npc = mpc + 16'd1 + ins[15:0]; end
        6'h02: begin lat = 3 + iw; npc = ins[15:0]; end
        default: begin expHalt = 1'b1; return; end
      endcase
      if (wr && wi != 0) mReg[wi] = res & mask;
      mpc = npc;
      e.lat = lat; e.pc = mpc; expLat.push_back(e);
    end
  endtask

  // Memory responders: ack after iw/dw wait cycles, driven 1 time unit after the edge
  initial begin
    busIAck = 1'b0; busDAck = 1'b0; busIData = '0; busDRdata = '0;
    cyc = 0; iCnt = 0; dCnt = 0;
    forever begin
      @(posedge clk);
      cyc = rst ? 0 : cyc + 1;
      #1;
      if (busIReq) begin
        busIAck = (iCnt >= iw); busIData = imem[busIAddr[9:0]]; iCnt++;
      end else begin
        busIAck = spur; busIData = spur ? 32'hFFFF_FFFF : 32'h0; iCnt = 0;
      end
      if (busDReq) begin
        busDAck = (dCnt >= dw); busDRdata = dmem[busDAddr[7:0]]; dCnt++;
      end else begin
        busDAck = 1'b0; dCnt = 0;
      end
    end
  end

  initial begin
    hValid = 1'b0; lastRet = 1; hAddr = '0; hData = '0; hWe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !monOn) begin
        lastRet = 1; hValid = 1'b0;
      end else begin
        if (busDReq) begin
          if (hValid) begin
            chk("dAddrStable", busDAddr, hAddr);
            chk("dWdataStable", busDWdata, hData);
            chk("dWeStable", busDWe, hWe);
          end
          hAddr = busDAddr; hData = busDWdata; hWe = busDWe; hValid = !busDAck;
        end else hValid = 1'b0;
        if (busDReq && busDWe && busDAck) begin
          dmem[busDAddr[7:0]] = busDWdata;
          chk("storeExpected", expSt.size() != 0, 1);
          if (expSt.size() != 0) begin
            stT s;
            s = expSt.pop_front();
            chk("storeAddr", busDAddr, s.addr);
            chk("storeData", busDWdata, s.data);
          end
        end
        if (busRet) begin
          chk("retireExpected", expLat.size() != 0, 1);
          if (expLat.size() != 0) begin
            latT e;
            e = expLat.pop_front();
            chk("retireLatency", 64'(cyc - lastRet), 64'(e.lat));
            chk("retirePc", busPc, e.pc);
          end
          lastRet = cyc;
        end
      end
    end
  end

  task automatic clearImem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'hFC00_0000;
  endtask

  task automatic runPhase(input string name, input bit useB, input int iwv, input int dwv,
                          input int maxSteps, input bit spurV);
    rst = 1'b1; monOn = 1'b0; sel = useB; iw = iwv; dw = dwv; spur = spurV;
    xl = useB ? 64 : 32; nr = useB ? 8 : 32;
    expLat.delete(); expSt.delete();
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    runIss(maxSteps);
    repeat (2) @(negedge clk);
    #1;
    chk({name, ":rstIReq"}, busIReq, 0);
    chk({name, ":rstDReq"}, busDReq, 0);
    chk({name, ":rstRetire"}, busRet, 0);
    chk({name, ":rstHalted"}, busHalt, 0);
    chk({name, ":rstPc"}, busPc, 0);
    @(negedge clk);
    monOn = 1'b1; rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (expLat.size() == 0 && (!expHalt || busHalt)) break;
    end
    if (expHalt) begin
      chk({name, ":halted"}, busHalt, 1);
      repeat (6) begin
        @(negedge clk);
        chk({name, ":quietInHalt"}, {busIReq, busDReq, busHalt}, 3'b001);
      end
    end
    monOn = 1'b0;
    chk({name, ":retiresDrained"}, expLat.size(), 0);
    chk({name, ":storesDrained"}, expSt.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; monOn = 1'b0; spur = 1'b0; iw = 0; dw = 0; xl = 32; nr = 32;

    // ALU ops, $0 writes, jump and both branch outcomes, ending on opcode 0x3F
    clearImem();
    imem[0]  = iT(6'h08, 0, 1, 5);
    imem[1]  = iT(6'h08, 0, 2, -3);
    imem[2]  = rT(1, 2, 3, 6'h20);
    imem[3]  = rT(2, 1, 4, 6'h2A);
    imem[4]  = rT(1, 2, 5, 6'h22);
    imem[5]  = rT(1, 2, 6, 6'h24);
    imem[6]  = rT(1, 2, 7, 6'h25);
    imem[7]  = rT(1, 2, 8, 6'h2A);
    imem[8]  = iT(6'h08, 0, 0, 7);
    imem[9]  = iT(6'h2B, 0, 3, 0);
    imem[10] = iT(6'h2B, 0, 4, 1);
    imem[11] = iT(6'h2B, 0, 5, 2);
    imem[12] = iT(6'h2B, 0, 6, 3);
    imem[13] = iT(6'h2B, 0, 7, 4);
    imem[14] = iT(6'h2B, 0, 8, 5);
    imem[15] = iT(6'h2B, 0, 0, 6);
    imem[16] = jT(32'h20);
    imem[32] = iT(6'h04, 1, 2, 5);
    imem[33] = iT(6'h04, 1, 1, 2);
    imem[36] = iT(6'h2B, 1, 1, 7);
    runPhase("alu", 1'b0, 0, 0, 100, 1'b0);

    // Store then load through a slow data memory, ending on an unsupported funct
    clearImem();
    imem[0] = iT(6'h08, 0, 1, 5);
    imem[1] = iT(6'h2B, 0, 1, 8);
    imem[2] = iT(6'h23, 0, 5, 8);
    imem[3] = iT(6'h2B, 0, 5, 9);
    imem[4] = rT(1, 1, 2, 6'h21);
    runPhase("mem", 1'b0, 0, 3, 100, 1'b0);

    // Self-loop branch at pc 10
    clearImem();
    imem[0]  = jT(10);
    imem[10] = iT(6'h04, 0, 0, -1);
    runPhase("loop", 1'b0, 0, 0, 6, 1'b0);

    // 64-bit, 8-register core with slow fetch and stray fetch acks
    clearImem();
    imem[0] = iT(6'h08, 0, 9, 1);
    imem[1] = iT(6'h08, 0, 2, -1);
    imem[2] = rT(2, 1, 3, 6'h20);
    imem[3] = iT(6'h2B, 0, 3, 0);
    imem[4] = iT(6'h2B, 0, 9, 1);
    imem[5] = iT(6'h2B, 0, 2, 2);
    imem[6] = rT(2, 1, 4, 6'h2A);
    imem[7] = iT(6'h2B, 0, 4, 3);
    runPhase("wide", 1'b1, 2, 1, 100, 1'b1);

    // Reset asserted while a store is waiting for its ack
    rst = 1'b1; sel = 1'b0; monOn = 1'b0; spur = 1'b0; iw = 0; dw = 40;
    clearImem();
    imem[0] = iT(6'h2B, 0, 0, 3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20 && !busDReq; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("midMem:dReqBefore", busDReq, 1);
    chk("midMem:pcBefore", busPc, 1);
    rst = 1'b1;
    #1;
    chk("midMem:dReqDropped", busDReq, 0);
    chk("midMem:pcReset", busPc, 0);
    chk("midMem:iReq", busIReq, 0);
    chk("midMem:retire", busRet, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postRst:noReqInStart", busIReq, 0);
    @(posedge clk); #1;
    chk("postRst:firstFetch", busIReq, 1);
    chk("postRst:fetchAddr", busIAddr, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
